// File: rtl/varint_pkg.sv
// rtl/varint_pkg.sv - shared varint constants, FSM state encodings and sizing helper
package varint_pkg;

    // Byte layout: bit 7 flags "more bytes follow", bits 6:0 carry payload.
    localparam int VARINT_CONT_BIT  = 7;
    localparam int VARINT_PAYLOAD_W = 7;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ACCUM = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_PUSH  = 4'b1000
    } varint_state_e;

    // Number of 7-bit groups needed to hold a data_w-bit value.
    function automatic int max_bytes(input int data_w);
        return (data_w + VARINT_PAYLOAD_W - 1) / VARINT_PAYLOAD_W;
    endfunction

endpackage

// File: rtl/varint_byte_merge.sv
// rtl/varint_byte_merge.sv - merge one varint payload group into a partial accumulator
//
// Ports:
//   i_acc      - accumulator before this byte
//   i_payload  - bits 6:0 of the incoming varint byte
//   i_byte_idx - position of the byte within the current word (0 = LSB group)
//   o_acc      - accumulator with this group OR-ed in at 7*i_byte_idx
//   o_overflow - last permitted byte carries payload bits beyond DATA_W
module varint_byte_merge
    import varint_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BYTES = max_bytes(DATA_W),
    parameter int IDX_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic [DATA_W-1:0]           i_acc,
    input  logic [VARINT_PAYLOAD_W-1:0] i_payload,
    input  logic [IDX_W-1:0]            i_byte_idx,
    output logic [DATA_W-1:0]           o_acc,
    output logic                        o_overflow
);

    localparam int SH_W   = $clog2(VARINT_PAYLOAD_W * MAX_BYTES);
    // Payload bits of the final group that still land inside DATA_W.
    localparam int LAST_W = DATA_W - VARINT_PAYLOAD_W * (MAX_BYTES - 1);

    logic [SH_W-1:0]             w_shamt;
    logic [DATA_W-1:0]           w_shifted;
    logic [VARINT_PAYLOAD_W-1:0] w_high;

    assign w_shamt   = SH_W'(i_byte_idx) * SH_W'(VARINT_PAYLOAD_W);
    // Shifting at DATA_W width drops any payload bits above the value width.
    assign w_shifted = DATA_W'(i_payload) << w_shamt;
    assign o_acc     = i_acc | w_shifted;

    assign w_high     = i_payload >> LAST_W;
    assign o_overflow = (i_byte_idx == IDX_W'(MAX_BYTES - 1)) && (w_high != '0);

endmodule

// File: rtl/varint_decode_fsm.sv
// rtl/varint_decode_fsm.sv - protobuf varint byte stream to DATA_W-bit word decoder
//
// Ports:
//   clk, reset_n     - clock (rising edge) and asynchronous active-low reset
//   byte_fifo_empty  - input byte FIFO empty
//   byte_data_in     - FWFT head of byte FIFO, valid while !byte_fifo_empty
//   byte_fifo_pop    - consume the head byte this cycle
//   value_fifo_full  - output value FIFO full
//   value_fifo_push  - write value_data_out/value_err this cycle
//   value_data_out   - decoded value (registered, 0 on error words)
//   value_err        - pushed word overflowed DATA_W or exceeded MAX_BYTES
//   err_count        - saturating count of error words pushed
module varint_decode_fsm
    import varint_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 byte_fifo_empty,
    input  logic [7:0]           byte_data_in,
    output logic                 byte_fifo_pop,
    input  logic                 value_fifo_full,
    output logic                 value_fifo_push,
    output logic [DATA_W-1:0]    value_data_out,
    output logic                 value_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int MAX_BYTES = max_bytes(DATA_W);
    localparam int IDX_W     = $clog2(MAX_BYTES + 1);

    varint_state_e          r_state;
    logic [DATA_W-1:0]      r_acc;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_W-1:0]      r_value;
    logic                   r_err;
    logic [ERR_CNT_W-1:0]   r_err_count;

    varint_state_e          w_state_nxt;
    logic [DATA_W-1:0]      w_acc_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [DATA_W-1:0]      w_value_nxt;
    logic                   w_err_nxt;
    logic [ERR_CNT_W-1:0]   w_err_count_nxt;
    logic                   w_pop;
    logic                   w_push;

    logic [DATA_W-1:0]      w_merged;
    logic                   w_overflow;
    logic                   w_cont;

    assign w_cont = byte_data_in[VARINT_CONT_BIT];

    varint_byte_merge #(
        .DATA_W    (DATA_W),
        .MAX_BYTES (MAX_BYTES),
        .IDX_W     (IDX_W)
    ) u_merge (
        .i_acc      (r_acc),
        .i_payload  (byte_data_in[VARINT_PAYLOAD_W-1:0]),
        .i_byte_idx (r_idx),
        .o_acc      (w_merged),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_value     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_idx       <= w_idx_nxt;
            r_value     <= w_value_nxt;
            r_err       <= w_err_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_idx_nxt       = r_idx;
        w_value_nxt     = r_value;
        w_err_nxt       = r_err;
        w_err_count_nxt = r_err_count;
        w_pop           = 1'b0;
        w_push          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Clear the word context here so ACCUM never needs a first-byte special case.
                w_acc_nxt = '0;
                w_idx_nxt = '0;
                if (!byte_fifo_empty) begin
                    w_state_nxt = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (!byte_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_acc_nxt = w_merged;
                    if (w_overflow) begin
                        w_value_nxt = '0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = w_cont ? ST_DRAIN : ST_PUSH;
                    end else if (!w_cont) begin
                        w_value_nxt = w_merged;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ST_PUSH;
                    end else if (r_idx == IDX_W'(MAX_BYTES - 1)) begin
                        // Last permitted byte still says "more": word is too long.
                        w_value_nxt = '0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // Discard the tail of a bad word up to and including its terminal byte.
                if (!byte_fifo_empty) begin
                    w_pop = 1'b1;
                    if (!w_cont) begin
                        w_state_nxt = ST_PUSH;
                    end
                end
            end

            ST_PUSH: begin
                if (!value_fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (r_err && (r_err_count != '1)) begin
                        w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign byte_fifo_pop   = w_pop;
    assign value_fifo_push = w_push;
    assign value_data_out  = r_value;
    assign value_err       = r_err;
    assign err_count       = r_err_count;

endmodule

// File: tb/tb_varint_decode_fsm.sv
// tb/tb_varint_decode_fsm.sv - self-checking bench for varint_decode_fsm
module tb_varint_decode_fsm;

    localparam int DATA_W    = 32;
    localparam int ERR_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 byte_fifo_empty = 1'b1;
    logic [7:0]           byte_data_in = 8'h00;
    logic                 byte_fifo_pop;
    logic                 value_fifo_full = 1'b0;
    logic                 value_fifo_push;
    logic [DATA_W-1:0]    value_data_out;
    logic                 value_err;
    logic [ERR_CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    varint_decode_fsm #(
        .DATA_W    (DATA_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .byte_fifo_empty (byte_fifo_empty),
        .byte_data_in    (byte_data_in),
        .byte_fifo_pop   (byte_fifo_pop),
        .value_fifo_full (value_fifo_full),
        .value_fifo_push (value_fifo_push),
        .value_data_out  (value_data_out),
        .value_err       (value_err),
        .err_count       (err_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  q_bytes[$];
    logic [7:0]  w_buf[$];
    logic [31:0] exp_val[$];
    logic        exp_err[$];
    int          exp_err_cnt = 0;

    int gap_pct  = 0;
    int full_pct = 0;
    bit full_hold = 1'b0;
    int cyc = 0;
    int pop_cnt = 0;
    int push_cnt = 0;
    int last_pop_cyc = -1;
    int last_push_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Load n bytes, LSB byte first, into the staging word buffer.
    task automatic load(input logic [63:0] seq, input int n);
        for (int i = 0; i < n; i++) w_buf.push_back(seq[8*i +: 8]);
    endtask

    task automatic bump_err_cnt();
        if (exp_err_cnt < (1 << ERR_CNT_W) - 1) exp_err_cnt++;
    endtask

    // Directed word: expectation given explicitly.
    task automatic commit_expect(input logic [31:0] v, input logic e);
        foreach (w_buf[i]) q_bytes.push_back(w_buf[i]);
        w_buf.delete();
        exp_val.push_back(v);
        exp_err.push_back(e);
        if (e) bump_err_cnt();
    endtask

    // Reference model: a word is valid iff it has at most 5 bytes and its value fits in 32 bits.
    task automatic commit_model();
        longint unsigned v;
        int n;
        bit ok;
        v = 0;
        n = w_buf.size();
        foreach (w_buf[i]) begin
            if (i < 9) v = v | (64'(w_buf[i][6:0]) << (7 * i));
            q_bytes.push_back(w_buf[i]);
        end
        ok = (n <= 5) && (v < 64'h1_0000_0000);
        exp_val.push_back(ok ? v[31:0] : 32'h0);
        exp_err.push_back(!ok);
        if (!ok) bump_err_cnt();
        w_buf.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        byte_fifo_empty = (q_bytes.size() == 0) || ($urandom_range(0, 99) < gap_pct);
        byte_data_in    = byte_fifo_empty ? 8'h00 : q_bytes[0];
        value_fifo_full = full_hold || ($urandom_range(0, 99) < full_pct);
        #1;
        if (byte_fifo_empty) check("pop_when_empty", byte_fifo_pop, 1'b0);
        else if (byte_fifo_pop) begin
            void'(q_bytes.pop_front());
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        if (value_fifo_full) check("push_when_full", value_fifo_push, 1'b0);
        else if (exp_val.size() == 0) check("extra_push", value_fifo_push, 1'b0);
        else if (value_fifo_push) begin
            check("value", value_data_out, exp_val.pop_front());
            check("err", value_err, exp_err.pop_front());
            push_cnt++;
            last_push_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic run_all(input string tag);
        int budget;
        budget = 5000;
        while ((q_bytes.size() > 0 || exp_val.size() > 0) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, 64'(exp_val.size()), 64'd0);
        tick();
        tick();
        check({tag, "_err_count"}, err_count, 64'(exp_err_cnt));
    endtask

    task automatic gen_random(input int n_words);
        logic [31:0] v;
        logic [7:0]  b;
        int mode;
        int n;
        for (int w = 0; w < n_words; w++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                v = $urandom() >> $urandom_range(0, 31);
                do begin
                    b = {1'b0, v[6:0]};
                    v = v >> 7;
                    b[7] = (v != 0);
                    w_buf.push_back(b);
                end while (v != 0);
            end else if (mode == 1) begin
                n = $urandom_range(1, 7);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom());
                    b[7] = (i != n - 1);
                    w_buf.push_back(b);
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    b = 8'($urandom());
                    b[7] = 1'b1;
                    w_buf.push_back(b);
                end
                w_buf.push_back(8'($urandom_range(0, 127)));
            end
            commit_model();
        end
    endtask

    initial begin
        int pops0;
        int pushes0;
        int budget;

        #12;
        check("rst_pop", byte_fifo_pop, 1'b0);
        check("rst_push", value_fifo_push, 1'b0);
        check("rst_value", value_data_out, 32'h0);
        check("rst_err", value_err, 1'b0);
        check("rst_err_count", err_count, 8'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single-byte words.
        load(64'h00, 1); commit_expect(32'h0000_0000, 1'b0);
        load(64'h7F, 1); commit_expect(32'h0000_007F, 1'b0);
        run_all("single");

        // 300: two pops back to back, push the cycle after the second pop.
        pops0 = pop_cnt;
        load(64'h02AC, 2); commit_expect(32'd300, 1'b0);
        run_all("v300");
        check("v300_pops", 64'(pop_cnt - pops0), 64'd2);
        check("v300_latency", 64'(last_push_cyc - last_pop_cyc), 64'd1);

        // Largest value, then overflow in the final group.
        load(64'h0F_FF_FF_FF_FF, 5); commit_expect(32'hFFFF_FFFF, 1'b0);
        load(64'h1F_FF_FF_FF_FF, 5); commit_expect(32'h0, 1'b1);
        run_all("maxovf");
        check("ovf_err_count", err_count, 8'd1);

        // Too long: seven bytes consumed as one error word, then a clean word.
        pops0 = pop_cnt;
        load(64'h01_80_80_80_80_80_80, 7); commit_expect(32'h0, 1'b1);
        load(64'h05, 1); commit_expect(32'd5, 1'b0);
        run_all("toolong");
        check("toolong_pops", 64'(pop_cnt - pops0), 64'd8);

        // Output FIFO full for 10 cycles while a word waits in PUSH.
        full_hold = 1'b1;
        pops0 = pop_cnt;
        pushes0 = push_cnt;
        load(64'h05, 1); commit_expect(32'd5, 1'b0);
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_value", value_data_out, 32'd5);
        end
        check("hold_pops", 64'(pop_cnt - pops0), 64'd1);
        check("hold_pushes", 64'(push_cnt - pushes0), 64'd0);
        full_hold = 1'b0;
        run_all("hold");
        check("hold_release_pushes", 64'(push_cnt - pushes0), 64'd1);

        // Same directed words with random empty gaps.
        gap_pct = 50;
        load(64'h02AC, 2); commit_expect(32'd300, 1'b0);
        load(64'h0F_FF_FF_FF_FF, 5); commit_expect(32'hFFFF_FFFF, 1'b0);
        run_all("gaps");
        gap_pct = 0;

        // Randomized words against the reference model, with gaps and backpressure.
        gap_pct = 30;
        full_pct = 30;
        gen_random(80);
        run_all("random");
        gap_pct = 0;
        full_pct = 0;

        // Reset in the middle of a word.
        load(64'h7F, 1); commit_expect(32'h7F, 1'b0);
        run_all("pre_reset");
        pops0 = pop_cnt;
        q_bytes.push_back(8'h80);
        q_bytes.push_back(8'h80);
        budget = 50;
        while (pop_cnt - pops0 < 2 && budget > 0) begin
            tick();
            budget--;
        end
        check("midword_pops", 64'(pop_cnt - pops0), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_value", value_data_out, 32'h0);
        check("areset_err", value_err, 1'b0);
        check("areset_err_count", err_count, 8'h0);
        check("areset_pop", byte_fifo_pop, 1'b0);
        check("areset_push", value_fifo_push, 1'b0);
        exp_err_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        load(64'h01, 1); commit_expect(32'h1, 1'b0);
        run_all("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
